// File: rtl/dfi_rddata_checker.sv
// ============================================================================
// Module : dfi_rddata_checker
// Brief  : Two-stage DFI read-data checker. Valid phases become a word stream
//          that is compared against seed + burst index, with saturating stats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dfi_rddata_checker #(
    parameter int pDFI_RDDATA_WIDTH       = 48,
    parameter int pDFI_RDDATA_VALID_WIDTH = 3,
    parameter int pCNT_WIDTH              = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [1:0]                         freq_ratio,
    input  logic [pDFI_RDDATA_VALID_WIDTH-1:0] lane_mask,
    input  logic [pDFI_RDDATA_WIDTH-1:0]       seed,
    input  logic                               cmp_en,
    input  logic                               clr,
    input  logic [pDFI_RDDATA_VALID_WIDTH-1:0] dfi_rddata_valid_W0,
    input  logic [pDFI_RDDATA_VALID_WIDTH-1:0] dfi_rddata_valid_W1,
    input  logic [pDFI_RDDATA_VALID_WIDTH-1:0] dfi_rddata_valid_W2,
    input  logic [pDFI_RDDATA_VALID_WIDTH-1:0] dfi_rddata_valid_W3,
    input  logic [pDFI_RDDATA_WIDTH-1:0]       dfi_rddata_W0,
    input  logic [pDFI_RDDATA_WIDTH-1:0]       dfi_rddata_W1,
    input  logic [pDFI_RDDATA_WIDTH-1:0]       dfi_rddata_W2,
    input  logic [pDFI_RDDATA_WIDTH-1:0]       dfi_rddata_W3,
    output logic [pCNT_WIDTH-1:0]              word_cnt,
    output logic [pCNT_WIDTH-1:0]              mismatch_cnt,
    output logic                               burst_done,
    output logic [pCNT_WIDTH-1:0]              burst_words,
    output logic                               first_mm_valid,
    output logic [pCNT_WIDTH-1:0]              first_mm_idx,
    output logic                               error,
    output logic                               protocol_err
);

    localparam int DW     = pDFI_RDDATA_WIDTH;
    localparam int CW     = pCNT_WIDTH;
    localparam int LANE_W = pDFI_RDDATA_WIDTH / pDFI_RDDATA_VALID_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [2:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW+1)'(b);
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    logic [DW-1:0] bit_mask;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_mask
            assign bit_mask[gi] = lane_mask[gi / LANE_W];
        end
    endgenerate

    // Stage 1 registers
    logic [3:0]          phase_en;
    logic [3:0]          vld_s1_d, vld_s1_q;
    logic [3:0][DW-1:0]  dat_s1_d, dat_s1_q;
    logic [DW-1:0]       msk_s1_d, msk_s1_q;

    // Stage 2 state
    state_t              state_d, state_q;
    logic [CW-1:0]       idx_d, idx_q;
    logic [CW-1:0]       burst_cnt_d, burst_cnt_q;
    logic [CW-1:0]       word_cnt_d, word_cnt_q;
    logic [CW-1:0]       mismatch_cnt_d, mismatch_cnt_q;
    logic                burst_done_d, burst_done_q;
    logic [CW-1:0]       burst_words_d, burst_words_q;
    logic                first_mm_valid_d, first_mm_valid_q;
    logic [CW-1:0]       first_mm_idx_d, first_mm_idx_q;
    logic                error_d, error_q;
    logic                protocol_err_d, protocol_err_q;

    logic [2:0]          nvalid;
    logic [2:0]          mm_n;
    logic                mm_any;
    logic [CW-1:0]       mm_first_idx;
    logic [CW-1:0]       widx [4];
    logic [DW-1:0]       expw [4];
    logic                gap;

    always_comb begin
        case (freq_ratio)
            2'd1:       phase_en = 4'b0011;
            2'd2, 2'd3: phase_en = 4'b1111;
            default:    phase_en = 4'b0001;
        endcase
        vld_s1_d[0] = phase_en[0] & (|(dfi_rddata_valid_W0 & lane_mask));
        vld_s1_d[1] = phase_en[1] & (|(dfi_rddata_valid_W1 & lane_mask));
        vld_s1_d[2] = phase_en[2] & (|(dfi_rddata_valid_W2 & lane_mask));
        vld_s1_d[3] = phase_en[3] & (|(dfi_rddata_valid_W3 & lane_mask));
        dat_s1_d    = {dfi_rddata_W3, dfi_rddata_W2, dfi_rddata_W1, dfi_rddata_W0};
        msk_s1_d    = bit_mask;
    end

    // Flatten valid phases in order; !== makes an X/Z compare count as a mismatch.
    always_comb begin
        nvalid       = 3'd0;
        mm_n         = 3'd0;
        mm_any       = 1'b0;
        mm_first_idx = '0;
        for (int p = 0; p < 4; p++) begin
            widx[p] = idx_q + CW'(nvalid);
            expw[p] = seed + DW'(widx[p]);
            if (vld_s1_q[p]) begin
                if (((dat_s1_q[p] ^ expw[p]) & msk_s1_q) !== '0) begin
                    if (!mm_any) begin
                        mm_first_idx = widx[p];
                    end
                    mm_any = 1'b1;
                    mm_n   = mm_n + 3'd1;
                end
                nvalid = nvalid + 3'd1;
            end
        end
        gap = |(vld_s1_q & (vld_s1_q + 4'd1));
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        burst_cnt_d      = burst_cnt_q;
        word_cnt_d       = word_cnt_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        burst_done_d     = 1'b0;
        burst_words_d    = burst_words_q;
        first_mm_valid_d = first_mm_valid_q;
        first_mm_idx_d   = first_mm_idx_q;
        error_d          = error_q;
        protocol_err_d   = protocol_err_q;

        if (clr) begin
            state_d          = ST_IDLE;
            idx_d            = '0;
            burst_cnt_d      = '0;
            word_cnt_d       = '0;
            mismatch_cnt_d   = '0;
            burst_words_d    = '0;
            first_mm_valid_d = 1'b0;
            first_mm_idx_d   = '0;
            error_d          = 1'b0;
            protocol_err_d   = 1'b0;
        end else begin
            word_cnt_d = sat_add(word_cnt_q, nvalid);
            if (gap) begin
                protocol_err_d = 1'b1;
            end
            if (cmp_en && mm_any) begin
                mismatch_cnt_d = sat_add(mismatch_cnt_q, mm_n);
                error_d        = 1'b1;
                if (!first_mm_valid_q) begin
                    first_mm_valid_d = 1'b1;
                    first_mm_idx_d   = mm_first_idx;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (nvalid != 3'd0) begin
                        state_d     = ST_ACTIVE;
                        idx_d       = idx_q + CW'(nvalid);
                        burst_cnt_d = sat_add(burst_cnt_q, nvalid);
                    end
                end
                ST_ACTIVE: begin
                    if (nvalid != 3'd0) begin
                        idx_d       = idx_q + CW'(nvalid);
                        burst_cnt_d = sat_add(burst_cnt_q, nvalid);
                    end else begin
                        state_d       = ST_IDLE;
                        burst_done_d  = 1'b1;
                        burst_words_d = burst_cnt_q;
                        burst_cnt_d   = '0;
                        idx_d         = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1_q         <= '0;
            dat_s1_q         <= '0;
            msk_s1_q         <= '0;
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            burst_cnt_q      <= '0;
            word_cnt_q       <= '0;
            mismatch_cnt_q   <= '0;
            burst_done_q     <= 1'b0;
            burst_words_q    <= '0;
            first_mm_valid_q <= 1'b0;
            first_mm_idx_q   <= '0;
            error_q          <= 1'b0;
            protocol_err_q   <= 1'b0;
        end else begin
            vld_s1_q         <= vld_s1_d;
            dat_s1_q         <= dat_s1_d;
            msk_s1_q         <= msk_s1_d;
            state_q          <= state_d;
            idx_q            <= idx_d;
            burst_cnt_q      <= burst_cnt_d;
            word_cnt_q       <= word_cnt_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            burst_done_q     <= burst_done_d;
            burst_words_q    <= burst_words_d;
            first_mm_valid_q <= first_mm_valid_d;
            first_mm_idx_q   <= first_mm_idx_d;
            error_q          <= error_d;
            protocol_err_q   <= protocol_err_d;
        end
    end

    assign word_cnt       = word_cnt_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign burst_done     = burst_done_q;
    assign burst_words    = burst_words_q;
    assign first_mm_valid = first_mm_valid_q;
    assign first_mm_idx   = first_mm_idx_q;
    assign error          = error_q;
    assign protocol_err   = protocol_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dfi_rddata_checker.sv
// ============================================================================
// Module : tb_dfi_rddata_checker
// Brief  : Self-checking bench for dfi_rddata_checker with a word-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dfi_rddata_checker;

    localparam int DW = 48;
    localparam int VW = 3;
    localparam int CW = 16;
    localparam int LW = DW / VW;
    localparam int CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    freq_ratio = 2'd0;
    logic [VW-1:0] lane_mask = '0;
    logic [DW-1:0] seed = '0;
    logic          cmp_en = 1'b0;
    logic          clr = 1'b0;
    logic [VW-1:0] vld [4];
    logic [DW-1:0] dat [4];

    logic [CW-1:0] word_cnt, mismatch_cnt, burst_words, first_mm_idx;
    logic          burst_done, first_mm_valid, error, protocol_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Word-level reference state
    logic [3:0]    p_v;
    logic [DW-1:0] p_d [4];
    logic [DW-1:0] p_m;
    int unsigned   m_word, m_mm, m_idx, m_bcnt, m_bwords, m_first_idx;
    bit            m_first_v, m_err, m_perr, m_active, m_done;
    int            done_seen;
    int unsigned   bw_log [8];

    always #5 clk = ~clk;

    dfi_rddata_checker #(
        .pDFI_RDDATA_WIDTH(DW), .pDFI_RDDATA_VALID_WIDTH(VW), .pCNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .freq_ratio(freq_ratio), .lane_mask(lane_mask),
        .seed(seed), .cmp_en(cmp_en), .clr(clr),
        .dfi_rddata_valid_W0(vld[0]), .dfi_rddata_valid_W1(vld[1]),
        .dfi_rddata_valid_W2(vld[2]), .dfi_rddata_valid_W3(vld[3]),
        .dfi_rddata_W0(dat[0]), .dfi_rddata_W1(dat[1]),
        .dfi_rddata_W2(dat[2]), .dfi_rddata_W3(dat[3]),
        .word_cnt(word_cnt), .mismatch_cnt(mismatch_cnt), .burst_done(burst_done),
        .burst_words(burst_words), .first_mm_valid(first_mm_valid),
        .first_mm_idx(first_mm_idx), .error(error), .protocol_err(protocol_err)
    );

    function automatic logic [67:0] dut_vec();
        return {word_cnt, mismatch_cnt, burst_done, burst_words,
                first_mm_valid, first_mm_idx, error, protocol_err};
    endfunction

    function automatic logic [67:0] model_vec();
        return {CW'(m_word), CW'(m_mm), m_done, CW'(m_bwords),
                m_first_v, CW'(m_first_idx), m_err, m_perr};
    endfunction

    task automatic model_clear();
        m_word = 0; m_mm = 0; m_idx = 0; m_bcnt = 0; m_bwords = 0; m_first_idx = 0;
        m_first_v = 0; m_err = 0; m_perr = 0; m_active = 0; m_done = 0;
    endtask

    task automatic model_reset_all();
        model_clear();
        p_v = '0;
        p_m = '0;
        for (int p = 0; p < 4; p++) p_d[p] = '0;
    endtask

    // Walk the captured phases as a word list; each word's index is its burst position.
    task automatic model_stage2();
        int          nv;
        bit          hole;
        int unsigned wi;
        logic [DW-1:0] e;
        nv = 0; hole = 0;
        for (int p = 0; p < 4; p++) begin
            if (p_v[p]) begin
                wi = (m_idx + nv) % 65536;
                e  = seed + DW'(wi);
                if (hole) m_perr = 1;
                if (cmp_en && (((p_d[p] ^ e) & p_m) != '0)) begin
                    if (m_mm < CMAX) m_mm++;
                    if (!m_first_v) begin m_first_v = 1; m_first_idx = wi; end
                    m_err = 1;
                end
                if (m_word < CMAX) m_word++;
                if (m_bcnt < CMAX) m_bcnt++;
                nv++;
            end else begin
                hole = 1;
            end
        end
        m_done = 0;
        if (nv > 0) begin
            m_active = 1;
            m_idx = (m_idx + nv) % 65536;
        end else if (m_active) begin
            m_done = 1; m_bwords = m_bcnt; m_bcnt = 0; m_idx = 0; m_active = 0;
        end
    endtask

    task automatic capture();
        int nph;
        nph = (freq_ratio == 2'd0) ? 1 : (freq_ratio == 2'd1) ? 2 : 4;
        for (int p = 0; p < 4; p++) begin
            p_v[p] = (p < nph) && ((vld[p] & lane_mask) != '0);
            p_d[p] = dat[p];
        end
        for (int b = 0; b < DW; b++) p_m[b] = lane_mask[b / LW];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (clr) model_clear();
        else     model_stage2();
        capture();
        @(negedge clk);
        if (burst_done) begin
            if (done_seen < 8) bw_log[done_seen] = burst_words;
            done_seen++;
        end
    endtask

    task automatic set_cyc(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        for (int p = 0; p < 4; p++) vld[p] = v[p] ? 3'b111 : 3'b000;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
    endtask

    task automatic idle(input int n);
        set_cyc(4'h0, '0, '0, '0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clr_pulse();
        set_cyc(4'h0, '0, '0, '0, '0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        done_seen = 0;
    endtask

    task automatic test_reset();
        set_cyc(4'h0, '0, '0, '0, '0);
        model_reset_all();
        done_seen = 0;
        #12;
        total_cnt++;
        if (dut_vec() !== 68'h0) $display("FAIL reset_in got %h exp 0", dut_vec());
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(); cycle();
        total_cnt++;
        if (dut_vec() !== model_vec() || dut_vec() !== 68'h0)
            $display("FAIL reset_after got %h exp %h", dut_vec(), model_vec());
        else pass_cnt++;
    endtask

    task automatic test_full_burst();
        clr_pulse();
        freq_ratio = 2'd2; lane_mask = 3'b111; seed = 48'd1; cmp_en = 1'b1;
        set_cyc(4'hF, 48'd1, 48'd2, 48'd3, 48'd4); cycle();
        set_cyc(4'hF, 48'd5, 48'd6, 48'd7, 48'd8); cycle();
        idle(4);
        total_cnt++;
        if (word_cnt !== 16'd8) $display("FAIL full_word_cnt got %0d exp 8", word_cnt); else pass_cnt++;
        total_cnt++;
        if (mismatch_cnt !== 16'd0) $display("FAIL full_mismatch got %0d exp 0", mismatch_cnt); else pass_cnt++;
        total_cnt++;
        if (done_seen != 1) $display("FAIL full_done_pulses got %0d exp 1", done_seen); else pass_cnt++;
        total_cnt++;
        if (burst_words !== 16'd8 || error !== 1'b0)
            $display("FAIL full_bw_err got bw=%0d err=%0b exp bw=8 err=0", burst_words, error);
        else pass_cnt++;
    endtask

    task automatic run_lm_burst(input logic [VW-1:0] lm);
        logic [DW-1:0] s;
        clr_pulse();
        freq_ratio = 2'd1; lane_mask = lm; seed = 48'h10; cmp_en = 1'b1;
        s = seed;
        set_cyc(4'h3, s, s + 1, '0, '0); cycle();
        set_cyc(4'h3, s + 2, s + 3, '0, '0); cycle();
        set_cyc(4'h3, (s + 4) ^ 48'h0000_0001_0000, s + 5, '0, '0); cycle();
        idle(3);
    endtask

    task automatic test_lane_mask();
        run_lm_burst(3'b111);
        total_cnt++;
        if (mismatch_cnt !== 16'd1) $display("FAIL lm_mismatch got %0d exp 1", mismatch_cnt); else pass_cnt++;
        total_cnt++;
        if (first_mm_idx !== 16'd4 || first_mm_valid !== 1'b1 || error !== 1'b1)
            $display("FAIL lm_first_mm got idx=%0d v=%0b err=%0b exp idx=4 v=1 err=1",
                     first_mm_idx, first_mm_valid, error);
        else pass_cnt++;
        run_lm_burst(3'b101);
        total_cnt++;
        if (mismatch_cnt !== 16'd0 || error !== 1'b0 || word_cnt !== 16'd6)
            $display("FAIL lm_masked got mm=%0d err=%0b wc=%0d exp mm=0 err=0 wc=6",
                     mismatch_cnt, error, word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_protocol();
        clr_pulse();
        freq_ratio = 2'd2; lane_mask = 3'b111; seed = 48'h1234; cmp_en = 1'b1;
        set_cyc(4'b0010, '0, seed, '0, '0); cycle();
        idle(3);
        total_cnt++;
        if (protocol_err !== 1'b1) $display("FAIL proto_err got %0b exp 1", protocol_err); else pass_cnt++;
        total_cnt++;
        if (mismatch_cnt !== 16'd0 || word_cnt !== 16'd1 || burst_words !== 16'd1)
            $display("FAIL proto_words got mm=%0d wc=%0d bw=%0d exp 0/1/1", mismatch_cnt, word_cnt, burst_words);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] s;
        clr_pulse();
        freq_ratio = 2'd1; lane_mask = 3'b111; seed = 48'h100; cmp_en = 1'b1;
        s = seed;
        set_cyc(4'h3, s, s + 1, '0, '0); cycle();
        set_cyc(4'h3, s + 2, s + 3, '0, '0); cycle();
        idle(1);
        set_cyc(4'h3, s, s + 1, '0, '0); cycle();
        set_cyc(4'h3, s + 2, s + 3, '0, '0); cycle();
        set_cyc(4'h3, s + 4, s + 5, '0, '0); cycle();
        idle(3);
        total_cnt++;
        if (done_seen != 2) $display("FAIL b2b_pulses got %0d exp 2", done_seen); else pass_cnt++;
        total_cnt++;
        if (bw_log[0] != 4 || bw_log[1] != 6)
            $display("FAIL b2b_burst_words got %0d,%0d exp 4,6", bw_log[0], bw_log[1]);
        else pass_cnt++;
        total_cnt++;
        if (word_cnt !== 16'd10 || mismatch_cnt !== 16'd0)
            $display("FAIL b2b_counts got wc=%0d mm=%0d exp 10/0", word_cnt, mismatch_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        clr_pulse();
        freq_ratio = 2'd2; lane_mask = 3'b111; seed = '0; cmp_en = 1'b1;
        for (int c = 0; c < 16383; c++) begin
            set_cyc(4'hF, ~DW'(c * 4), ~DW'(c * 4 + 1), ~DW'(c * 4 + 2), ~DW'(c * 4 + 3));
            cycle();
        end
        set_cyc(4'h7, ~DW'(65532), ~DW'(65533), ~DW'(65534), '0); cycle();
        set_cyc(4'h1, ~DW'(65535), '0, '0, '0); cycle();
        total_cnt++;
        if (mismatch_cnt !== 16'hFFFF) $display("FAIL sat_preload got %h exp ffff", mismatch_cnt); else pass_cnt++;
        set_cyc(4'h0, '0, '0, '0, '0); cycle();
        total_cnt++;
        if (mismatch_cnt !== 16'hFFFF || word_cnt !== 16'hFFFF || dut_vec() !== model_vec())
            $display("FAIL sat_hold got %h exp %h", dut_vec(), model_vec());
        else pass_cnt++;
        idle(3);
        set_cyc(4'hF, '0, 48'd1, 48'd2, 48'd3); cycle();
        set_cyc(4'hF, 48'd4, 48'd5, 48'd6, 48'd7); cycle();
        set_cyc(4'h0, '0, '0, '0, '0);
        clr = 1'b1; cycle(); clr = 1'b0;
        total_cnt++;
        if (dut_vec() !== 68'h0) $display("FAIL clr_mid got %h exp 0", dut_vec()); else pass_cnt++;
        done_seen = 0;
        idle(3);
        total_cnt++;
        if (done_seen != 0 || word_cnt !== 16'd0)
            $display("FAIL clr_no_done got pulses=%0d wc=%0d exp 0/0", done_seen, word_cnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] s;
        clr_pulse();
        freq_ratio = 2'd2; lane_mask = 3'b111; seed = 48'h55; cmp_en = 1'b1;
        s = seed;
        set_cyc(4'hF, s, s + 1, s + 2, s + 3); cycle();
        set_cyc(4'hF, s + 4, s + 5, s + 6, s + 7); cycle();
        set_cyc(4'h0, '0, '0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset_all();
        total_cnt++;
        if (dut_vec() !== 68'h0) $display("FAIL arst_immediate got %h exp 0", dut_vec()); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        set_cyc(4'hF, s, s + 1, s + 2, s + 3); cycle();
        set_cyc(4'hF, s + 4, s + 5, s + 6, s + 7); cycle();
        idle(3);
        total_cnt++;
        if (mismatch_cnt !== 16'd0 || burst_words !== 16'd8 || word_cnt !== 16'd8 || done_seen != 1)
            $display("FAIL arst_new_burst got mm=%0d bw=%0d wc=%0d pulses=%0d exp 0/8/8/1",
                     mismatch_cnt, burst_words, word_cnt, done_seen);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int nph, np, len, drv;
        logic [3:0] on;
        clr_pulse();
        for (int b = 0; b < 40; b++) begin
            freq_ratio = 2'($urandom_range(0, 3));
            lane_mask  = 3'($urandom_range(1, 7));
            seed       = {16'($urandom), 32'($urandom)};
            cmp_en     = ($urandom_range(0, 3) != 0);
            nph        = (freq_ratio == 2'd0) ? 1 : (freq_ratio == 2'd1) ? 2 : 4;
            len        = $urandom_range(1, 6);
            drv        = 0;
            for (int c = 0; c < len; c++) begin
                np = $urandom_range(1, nph);
                on = 4'((1 << np) - 1);
                if (nph > 1 && $urandom_range(0, 7) == 0) on[0] = 1'b0;
                for (int p = 0; p < 4; p++) begin
                    if (p < nph && on[p]) begin
                        vld[p] = lane_mask | 3'($urandom);
                        dat[p] = seed + DW'(drv);
                        if ($urandom_range(0, 5) == 0) dat[p] ^= (DW'(1) << $urandom_range(0, DW - 1));
                        drv++;
                    end else begin
                        vld[p] = (p < nph) ? (3'($urandom) & ~lane_mask) : 3'($urandom);
                        dat[p] = {16'($urandom), 32'($urandom)};
                    end
                end
                cycle();
                total_cnt++;
                if (dut_vec() !== model_vec())
                    $display("FAIL rnd_burst b=%0d c=%0d got %h exp %h", b, c, dut_vec(), model_vec());
                else pass_cnt++;
            end
            set_cyc(4'h0, '0, '0, '0, '0);
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                cycle();
                total_cnt++;
                if (dut_vec() !== model_vec())
                    $display("FAIL rnd_idle b=%0d got %h exp %h", b, dut_vec(), model_vec());
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_lane_mask();
        test_protocol();
        test_back_to_back();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
